// File: rtl/mul_seq_signed.sv
// ---------------------------------------------------------------------------
// mul_seq_signed
//
// Sequential two's-complement multiplier with a register-mapped bus slave.
// One multiplier bit is consumed per clock (shift-add); the MSB of the
// multiplier carries negative weight, so its partial product is subtracted.
// The full 2*SZin-bit product is returned.
//
// Register map (addr):
//   0 : operand A     (write: load, read: sign-extended)
//   1 : operand B     (write: load, read: sign-extended)
//   2 : control/prod  (write: bit0 = start, read: product)
//   3 : status        (read: {zeros, mode, busy, done}, write: no effect)
//
// Ports:
//   clk    - system clock, all state changes on posedge
//   res    - asynchronous active-high reset
//   sel    - slave select; the bus is ignored while low
//   wrt    - 1 = write access, 0 = read access
//   addr   - register address
//   wdata  - write data (SZin bits)
//   rdata  - registered read data (2*SZin bits), holds while not read
//   ready  - 1 when writes/start are accepted (IDLE or DONE)
//   done   - 1 when the product register holds the last started result
//
// Optional feature macro: MUL_UNSIGNED_MODE_EN
//   When defined, control bit 1 written together with start selects
//   unsigned mode (1) or signed mode (0); the mode is latched at start and
//   reported in status bit 2. When undefined the block is signed only and
//   status bit 2 reads 0.
// ---------------------------------------------------------------------------
module mul_seq_signed #(
    parameter int SZin = 8,
    parameter int CNTW = $clog2(SZin) + 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic                sel,
    input  logic                wrt,
    input  logic [1:0]          addr,
    input  logic [SZin-1:0]     wdata,
    output logic [2*SZin-1:0]   rdata,
    output logic                ready,
    output logic                done
);

    localparam int PW = 2 * SZin;
    // Width needed to index one bit of the multiplier.
    localparam int IW = (SZin > 1) ? $clog2(SZin) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [SZin-1:0]   op_a;
    logic [SZin-1:0]   op_b;
    logic [SZin-1:0]   m_a;
    logic [SZin-1:0]   m_b;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     prod;
    logic [CNTW-1:0]   cnt;

`ifdef MUL_UNSIGNED_MODE_EN
    logic              mode_u;
`endif

    logic              write_en;
    logic              start;
    logic              last_bit;
    logic              subtract;
    logic              mode_bit;
    logic [IW-1:0]     bit_idx;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     status;

    assign write_en = sel && wrt && ready;
    assign start    = write_en && (addr == 2'd2) && wdata[0];
    assign last_bit = (cnt == CNTW'(SZin - 1));
    assign bit_idx  = cnt[IW-1:0];

`ifdef MUL_UNSIGNED_MODE_EN
    assign mode_bit = mode_u;
`else
    assign mode_bit = 1'b0;
`endif

    assign status = {{(PW-3){1'b0}}, mode_bit, (state == BUSY), done};

    // Partial product for the current multiplier bit. In signed mode the
    // MSB has weight -2^(SZin-1), so that step subtracts instead of adds;
    // everything wraps modulo 2^(2*SZin).
    always_comb begin
        a_ext    = {{SZin{m_a[SZin-1]}}, m_a};
        subtract = last_bit;
`ifdef MUL_UNSIGNED_MODE_EN
        if (mode_u) begin
            a_ext    = {{SZin{1'b0}}, m_a};
            subtract = 1'b0;
        end
`endif
        pp       = m_b[bit_idx] ? (a_ext << cnt) : '0;
        acc_next = subtract ? (acc - pp) : (acc + pp);
    end

    // Control FSM, datapath and bus register file in one sequential block.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            m_a   <= '0;
            m_b   <= '0;
            acc   <= '0;
            prod  <= '0;
            cnt   <= '0;
            rdata <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
`ifdef MUL_UNSIGNED_MODE_EN
            mode_u <= 1'b0;
`endif
        end else begin
            // Reads are served in every state and reflect pre-edge values.
            if (sel && !wrt) begin
                case (addr)
                    2'd0:    rdata <= {{SZin{op_a[SZin-1]}}, op_a};
                    2'd1:    rdata <= {{SZin{op_b[SZin-1]}}, op_b};
                    2'd2:    rdata <= prod;
                    default: rdata <= status;
                endcase
            end

            if (write_en && (addr == 2'd0)) begin
                op_a <= wdata;
            end
            if (write_en && (addr == 2'd1)) begin
                op_b <= wdata;
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Snapshot operands so later bus writes cannot
                        // disturb the running operation.
                        m_a   <= op_a;
                        m_b   <= op_b;
                        acc   <= '0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        done  <= 1'b0;
                        state <= BUSY;
`ifdef MUL_UNSIGNED_MODE_EN
                        mode_u <= wdata[1];
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        prod  <= acc_next;
                        ready <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_signed.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_signed
//
// Directed self-checking bench for mul_seq_signed with SZin = 8. Each
// scenario task drives the bus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mul_seq_signed;

    localparam int SZ = 8;

    logic            clk;
    logic            res;
    logic            sel;
    logic            wrt;
    logic [1:0]      addr;
    logic [SZ-1:0]   wdata;
    logic [2*SZ-1:0] rdata;
    logic            ready;
    logic            done;

    int vectors;
    int miscompares;

    mul_seq_signed #(.SZin(SZ)) dut (
        .clk   (clk),
        .res   (res),
        .sel   (sel),
        .wrt   (wrt),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus write: driven at negedge, sampled at posedge, released after.
    task automatic bus_write(input logic [1:0] a, input logic [SZ-1:0] d);
        @(negedge clk);
        sel   = 1'b1;
        wrt   = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        wrt   = 1'b0;
    endtask

    // One bus read; rdata is registered at the sampling edge.
    task automatic bus_read(input logic [1:0] a, output logic [2*SZ-1:0] d);
        @(negedge clk);
        sel  = 1'b1;
        wrt  = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        d    = rdata;
        sel  = 1'b0;
    endtask

    // Counts clock edges until done rises; gives up after a bounded budget.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Full operation: load operands, start, wait, read product.
    task automatic do_mul(input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                          input logic [SZ-1:0] ctrl,
                          output logic [2*SZ-1:0] p, output int cycles);
        bus_write(2'd0, a);
        bus_write(2'd1, b);
        bus_write(2'd2, ctrl);
        wait_done(cycles);
        bus_read(2'd2, p);
    endtask

    task automatic test_reset;
        logic [2*SZ-1:0] d;
        int              cyc;
        res = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || rdata !== 16'h0000) begin
            $display("[TB] FAIL reset_state: got ready=%b done=%b rdata=%h expected 1 0 0000",
                     ready, done, rdata);
            miscompares++;
        end
        @(negedge clk);
        res = 1'b0;

        do_mul(8'd2, 8'd5, 8'h01, d, cyc);
        vectors++;
        if (cyc !== 8) begin
            $display("[TB] FAIL latency_2x5: got %0d cycles expected 8", cyc);
            miscompares++;
        end
        vectors++;
        if (d !== 16'h000A) begin
            $display("[TB] FAIL prod_2x5: got %h expected 000a", d);
            miscompares++;
        end

        // Restart, then reset asynchronously during the 4th BUSY cycle.
        bus_write(2'd2, 8'h01);
        repeat (3) @(posedge clk);
        #2;
        res = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || rdata !== 16'h0000) begin
            $display("[TB] FAIL async_reset: got ready=%b done=%b rdata=%h expected 1 0 0000",
                     ready, done, rdata);
            miscompares++;
        end
        @(negedge clk);
        res = 1'b0;
        bus_read(2'd2, d);
        vectors++;
        if (d !== 16'h0000) begin
            $display("[TB] FAIL prod_after_reset: got %h expected 0000", d);
            miscompares++;
        end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 16'h0000) begin
            $display("[TB] FAIL status_after_reset: got %h expected 0000", d);
            miscompares++;
        end
    endtask

    task automatic test_signed;
        logic [SZ-1:0]   ta [6] = '{8'hFD, 8'h07, 8'hFF, 8'h80, 8'h7F, 8'h00};
        logic [SZ-1:0]   tb [6] = '{8'h07, 8'hFD, 8'hFF, 8'h80, 8'h80, 8'h80};
        logic [2*SZ-1:0] te [6] = '{16'hFFEB, 16'hFFEB, 16'h0001,
                                    16'h4000, 16'hC080, 16'h0000};
        logic [2*SZ-1:0] d;
        int              cyc;
        for (int i = 0; i < 6; i++) begin
            do_mul(ta[i], tb[i], 8'h01, d, cyc);
            vectors++;
            if (d !== te[i] || cyc !== 8) begin
                $display("[TB] FAIL signed_%0d: got %h after %0d cycles expected %h after 8",
                         i, d, cyc, te[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_busy_lockout;
        logic [2*SZ-1:0] d;
        int              cyc;
        bus_write(2'd0, 8'd4);
        bus_write(2'd1, 8'd4);
        bus_write(2'd2, 8'h01);
        bus_write(2'd0, 8'd9);
        vectors++;
        if (ready !== 1'b0) begin
            $display("[TB] FAIL ready_busy_1: got %b expected 0", ready);
            miscompares++;
        end
        bus_write(2'd2, 8'h01);
        vectors++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL ready_busy_2: got ready=%b done=%b expected 0 0", ready, done);
            miscompares++;
        end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 16'h0002) begin
            $display("[TB] FAIL status_busy: got %h expected 0002", d);
            miscompares++;
        end
        // Three edges already used since start; a dropped restart would add two.
        wait_done(cyc);
        vectors++;
        if (cyc !== 5) begin
            $display("[TB] FAIL latency_lockout: got %0d cycles expected 5", cyc);
            miscompares++;
        end
        bus_read(2'd2, d);
        vectors++;
        if (d !== 16'h0010) begin
            $display("[TB] FAIL prod_lockout: got %h expected 0010", d);
            miscompares++;
        end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 16'h0004) begin
            $display("[TB] FAIL opa_dropped: got %h expected 0004", d);
            miscompares++;
        end
        repeat (3) @(posedge clk);
        #1;
        bus_read(2'd3, d);
        vectors++;
        if (done !== 1'b1 || d !== 16'h0001) begin
            $display("[TB] FAIL done_holds: got done=%b status=%h expected 1 0001", done, d);
            miscompares++;
        end
        // sel low: no write takes effect and rdata holds.
        @(negedge clk);
        sel   = 1'b0;
        wrt   = 1'b1;
        addr  = 2'd0;
        wdata = 8'h55;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        vectors++;
        if (rdata !== 16'h0001) begin
            $display("[TB] FAIL rdata_hold: got %h expected 0001", rdata);
            miscompares++;
        end
        bus_read(2'd0, d);
        vectors++;
        if (d !== 16'h0004) begin
            $display("[TB] FAIL sel_low_write: got %h expected 0004", d);
            miscompares++;
        end
    endtask

    task automatic test_restart;
        logic [2*SZ-1:0] d;
        int              cyc;
        bus_write(2'd1, 8'hFE);
        vectors++;
        if (done !== 1'b1) begin
            $display("[TB] FAIL done_after_opwrite: got %b expected 1", done);
            miscompares++;
        end
        bus_read(2'd1, d);
        vectors++;
        if (d !== 16'hFFFE) begin
            $display("[TB] FAIL opb_signext: got %h expected fffe", d);
            miscompares++;
        end
        bus_write(2'd2, 8'h01);
        vectors++;
        if (done !== 1'b0 || ready !== 1'b0) begin
            $display("[TB] FAIL restart_edge: got done=%b ready=%b expected 0 0", done, ready);
            miscompares++;
        end
        wait_done(cyc);
        bus_read(2'd2, d);
        vectors++;
        if (d !== 16'hFFF8 || cyc !== 8) begin
            $display("[TB] FAIL restart_prod: got %h after %0d cycles expected fff8 after 8", d, cyc);
            miscompares++;
        end
    endtask

    task automatic test_mode;
        logic [2*SZ-1:0] d;
        int              cyc;
`ifdef MUL_UNSIGNED_MODE_EN
        do_mul(8'hFF, 8'hFF, 8'h03, d, cyc);
        vectors++;
        if (d !== 16'hFE01 || cyc !== 8) begin
            $display("[TB] FAIL unsigned_ff: got %h after %0d cycles expected fe01 after 8", d, cyc);
            miscompares++;
        end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 16'h0005) begin
            $display("[TB] FAIL status_unsigned: got %h expected 0005", d);
            miscompares++;
        end
`else
        do_mul(8'hFF, 8'hFF, 8'h03, d, cyc);
        vectors++;
        if (d !== 16'h0001 || cyc !== 8) begin
            $display("[TB] FAIL mode_bit_ignored: got %h after %0d cycles expected 0001 after 8", d, cyc);
            miscompares++;
        end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 16'h0001) begin
            $display("[TB] FAIL status_signed_only: got %h expected 0001", d);
            miscompares++;
        end
`endif
        do_mul(8'hFF, 8'hFF, 8'h01, d, cyc);
        vectors++;
        if (d !== 16'h0001) begin
            $display("[TB] FAIL signed_ff: got %h expected 0001", d);
            miscompares++;
        end
        bus_read(2'd3, d);
        vectors++;
        if (d !== 16'h0001) begin
            $display("[TB] FAIL status_signed: got %h expected 0001", d);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        res   = 1'b1;
        sel   = 1'b0;
        wrt   = 1'b0;
        addr  = 2'd0;
        wdata = '0;
        test_reset();
        test_signed();
        test_busy_lockout();
        test_restart();
        test_mode();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_seq_signed.md
Name: mul_seq_signed

Overview:
Sequential two's-complement multiplier, parametrised in operand width, with a register-mapped bus slave interface. It is the multi-cycle successor of the single-shot operand/result multiplier peripheral.
- Computes one multiplier bit per clock using shift-add with sign correction on the MSB.
- Returns a full-width 2*SZin product.
- Handshake uses a dedicated driven ready/done pair; there is no tristate line.
- Sits on the peripheral bus next to the other arithmetic slaves.

Parameters:
SZin, 8, operand width in bits (two's-complement); legal 2..32
CNTW, $clog2(SZin)+1, bit-counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on posedge
res  input  1  asynchronous active-high reset
sel  input  1  slave select; bus access only when 1
wrt  input  1  1 = write access, 0 = read access (qualified by sel)
addr  input  2  register address: 0 = op A, 1 = op B, 2 = control, 3 = status
wdata  input  SZin  write data
rdata  output  2*SZin  registered read data
ready  output  1  1 = slave accepts writes/start (state IDLE or DONE)
done  output  1  1 = product register valid for last started operation

Behaviour:
- Reset (async, res=1): state=IDLE; opA, opB, acc, prod, cnt = 0; rdata=0; ready=1; done=0. Reset mid-BUSY aborts the operation with no partial product kept.
- States:
  - IDLE: ready=1, done=0.
  - BUSY: ready=0.
  - DONE: ready=1, done=1.
- Writes (sel=1, wrt=1), honoured only when ready=1. In BUSY every write, including start, is silently dropped.
  - addr 0: opA <= wdata.
  - addr 1: opB <= wdata.
  - addr 2: if wdata[0]=1, start.
  - addr 3: no effect.
- Start, at edge E: state->BUSY, acc<=0, cnt<=0, done<=0. Operands are snapshotted into internal mA/mB, so bus writes after E do not affect the result.
- BUSY, each edge: let pp = mB[cnt] ? (sign-extended mA << cnt) : 0, at 2*SZin bits.
  - If cnt=SZin-1 (signed weight of MSB): acc <= acc - pp.
  - Otherwise: acc <= acc + pp.
  - cnt <= cnt+1.
- On the edge where cnt=SZin-1: prod <= final acc, state->DONE, done=1. Latency: done visible after edge E+SZin.
- Arithmetic is modulo 2^(2*SZin). The full product always fits, including -2^(SZin-1) * -2^(SZin-1).
- DONE persists until the next start or reset. Operand writes in DONE do not clear done.
- Start in DONE restarts the multiplier and clears done at that edge.
- Reads (sel=1, wrt=0), one-cycle latency: rdata registered at the edge where the read is sampled.
  - addr 0: opA sign-extended.
  - addr 1: opB sign-extended.
  - addr 2: prod.
  - addr 3: {zeros, busy, done}.
- Reads are allowed in any state. During BUSY, prod holds the previous result.
- sel=0: rdata holds its last value; no state change from the bus.
- Simultaneous read and write are impossible (single wrt line).

Optional Feature:
MUL_UNSIGNED_MODE_EN
- Defined: control register bit wdata[1], written together with start, selects the mode, latched at start.
  - 1 = unsigned: zero-extend mA, add at every bit including the MSB.
  - 0 = signed, as above.
  - Status addr 3 bit 2 reflects the latched mode.
- Undefined: wdata[1] is ignored, the block is signed only, and status bit 2 reads 0.

Test Plan:
SZin=8.
1. Reset mid-op: reset, write A=2, B=5, start -> done rises exactly 8 cycles after the start edge; read addr 2 -> rdata=16'h000A. Repeat, asserting res during cycle 4 of BUSY -> async clear: ready=1, done=0, prod=0, rdata=0 immediately.
2. Signed mixes: A=-3 (8'hFD), B=7 -> 16'hFFEB. A=7, B=-3 -> 16'hFFEB. A=-1, B=-1 -> 16'h0001.
3. Extremes: A=B=8'h80 -> 16'h4000. A=8'h7F, B=8'h80 -> 16'hC080. A=0, B=8'h80 -> 16'h0000.
4. Busy lockout: start A=4, B=4; during BUSY write A=9 and start again -> both dropped, ready=0 throughout, result 16'h0010, done pulses once and stays high. Status read during BUSY -> 2'b10.
5. Restart from DONE: after result 16'h0010, write B=8'hFE and start -> done drops at the start edge, result 16'hFFF8 after 8 cycles.
6. MUL_UNSIGNED_MODE_EN defined: A=B=8'hFF with wdata=2'b11 at start -> 16'hFE01, status bit 2 = 1. Same with wdata=2'b01 -> 16'h0001.
